// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive blocks of the FPGA link.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int UART_DATA_BITS       = 8;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps, with a synchronous clear.
// bit_end_o is registered and is high exactly while the count sits at its last value.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_o,
  output logic             bit_end_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             bit_end_q, bit_end_d;

  // Next count and look-ahead of the last-cycle flag.
  always_comb begin
    count_d   = count_q;
    bit_end_d = 1'b0;
    if (clear_i) begin
      count_d = '0;
    end else if (count_q == CNT_LAST) begin
      count_d = '0;
    end else begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    bit_end_d = (count_d == CNT_LAST);
  end

  // Counter and flag registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q   <= '0;
      bit_end_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      bit_end_q <= bit_end_d;
    end
  end

  assign count_o   = count_q;
  assign bit_end_o = bit_end_q;

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Pops bytes from fifo_ram while it is non-empty and sends each as an 8N1 UART frame.
// Every output is a register loaded from the next-state values, so it lines up with the state.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int READ_LATENCY = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_read,
  output logic       fifo_enable,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int               CNT_W      = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [1:0]       FETCH_LAST = 2'(READ_LATENCY);
  localparam logic [2:0]       BIT_LAST   = 3'(UART_DATA_BITS - 1);

  uart_state_e               state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [1:0]                fetch_cnt_q, fetch_cnt_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      read_q, read_d;
  logic                      done_q, done_d;

  logic                      baud_clear_s;
  logic [CNT_W-1:0]          baud_count_s;
  logic                      bit_end_s;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud (
    .clock_i  (clock),
    .reset_i  (reset),
    .clear_i  (baud_clear_s),
    .count_o  (baud_count_s),
    .bit_end_o(bit_end_s)
  );

  // Next-state, datapath and output look-ahead.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    fetch_cnt_d = fetch_cnt_q;
    read_d      = 1'b0;
    tx_d        = 1'b1;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        fetch_cnt_d = 2'd0;
        bit_idx_d   = 3'd0;
        if (!fifo_empty) begin
          state_d = ST_FETCH;
          read_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      // The pop cycle plus READ_LATENCY wait cycles; data is captured on the last one.
      ST_FETCH: begin
        if (fetch_cnt_q == FETCH_LAST) begin
          shift_d = fifo_data;
          state_d = ST_START;
        end else begin
          fetch_cnt_d = fetch_cnt_q + 2'd1;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          if (bit_idx_q == BIT_LAST) begin
            bit_idx_d = 3'd0;
            state_d   = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Counter restarts on every state entry and is held at zero outside the frame.
    baud_clear_s = (state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_FETCH);

    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_STOP) && (baud_count_s == CNT_PENULT);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_idx_q   <= 3'd0;
      fetch_cnt_q <= 2'd0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      read_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      fetch_cnt_q <= fetch_cnt_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      read_q      <= read_d;
      done_q      <= done_d;
    end
  end

  assign fifo_read   = read_q;
  assign fifo_enable = read_q;
  assign tx          = tx_q;
  assign busy        = busy_q;
  assign tx_done     = done_q;

endmodule
